// File: rtl/alu_pipe.sv
// alu_pipe: registered, valid/ready handshaked ALU with shifts and zero/neg/carry/err flags.
// Define ALU_PIPE_MUL_EN to build the iterative signed multiply (opcode 1011) and its BUSY state.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             err,
    output logic             carry,
    output logic             zero,
    output logic             neg
);
    // state | meaning
    // IDLE  | no result pending, ready for operands
    // BUSY  | shift-add multiply in progress (multiply builds only)
    // DONE  | result presented and held until out_ready

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_DEC = 4'b0010;
    localparam logic [3:0] OP_INC = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_SAR = 4'b1010;

    localparam int               SH_W  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_V = ~MIN_V;

`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1011;
    localparam int         CNT_W  = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

    state_t           state;
    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] c_res;
    logic             c_err;
    logic             c_carry;
    logic             big_shift;

    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign zero      = (res == '0);
    assign neg       = res[WIDTH-1];
    // WIDTH is a power of two, so any bit above log2(WIDTH) means b >= WIDTH
    assign big_shift = |(b >> SH_W);

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        c_res   = '0;
        c_err   = 1'b0;
        c_carry = 1'b0;
        case (op)
            OP_ADD: begin
                c_res   = sum[WIDTH-1:0];
                c_carry = sum[WIDTH];
                c_err   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                c_res   = a - b;
                c_carry = (a < b);
                c_err   = (a[WIDTH-1] != b[WIDTH-1]) && (c_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DEC: begin
                c_res   = a - ONE;
                c_err   = (a == MIN_V);
                c_carry = (a == '0);
            end
            OP_INC: begin
                c_res   = a + ONE;
                c_err   = (a == MAX_V);
                c_carry = (a == '1);
            end
            OP_NOT: c_res = ~a;
            OP_AND: c_res = a & b;
            OP_OR:  c_res = a | b;
            OP_XOR: c_res = a ^ b;
            OP_SHL: c_res = big_shift ? '0 : (a << b);
            OP_SHR: c_res = big_shift ? '0 : (a >> b);
            OP_SAR: c_res = big_shift ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> b);
            default: c_err = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [CNT_W-1:0]   cnt;
    logic               sgn;
    logic               mul_ovf;

    // magnitude of the most negative value still fits as an unsigned WIDTH-bit number
    assign mag_a   = a[WIDTH-1] ? ('0 - a) : a;
    assign mag_b   = b[WIDTH-1] ? ('0 - b) : b;
    assign prod_s  = sgn ? ('0 - prod) : prod;
    assign mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res       <= '0;
            err       <= 1'b0;
            carry     <= 1'b0;
        end else begin
            case (state)
`ifdef ALU_PIPE_MUL_EN
                BUSY: begin
                    if (cnt != '0) begin
                        if (mplier[0]) begin
                            prod <= prod + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - 1'b1;
                    end else begin
                        res       <= prod_s[WIDTH-1:0];
                        err       <= mul_ovf;
                        carry     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                default: begin
                    if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
`ifdef ALU_PIPE_MUL_EN
                        if (op == OP_MUL) begin
                            state     <= BUSY;
                            out_valid <= 1'b0;
                            mcand     <= {{WIDTH{1'b0}}, mag_a};
                            mplier    <= mag_b;
                            prod      <= '0;
                            cnt       <= CNT_W'(WIDTH);
                            sgn       <= a[WIDTH-1] ^ b[WIDTH-1];
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            res       <= c_res;
                            err       <= c_err;
                            carry     <= c_carry;
                        end
`else
                        state     <= DONE;
                        out_valid <= 1'b1;
                        res       <= c_res;
                        err       <= c_err;
                        carry     <= c_carry;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard testbench for alu_pipe: directed cases, backpressure, reset abort and random traffic
// checked against an integer-arithmetic reference model.
module tb_alu_pipe;
    localparam int W = 8;
    localparam logic [3:0] MUL_OP = 4'b1011;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res;
    logic         err, carry, zero, neg;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        logic         carry;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .err(err), .carry(carry), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic in_range(input longint s);
        return (s >= -(longint'(1) << (W-1))) && (s <= (longint'(1) << (W-1)) - 1);
    endfunction

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint sx, sy, ux, uy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        s = 0;
        e.err = 1'b0;
        e.carry = 1'b0;
        case (o)
            4'd0: begin s = sx + sy; e.err = !in_range(s); e.carry = (ux + uy) >= (longint'(1) << W); end
            4'd1: begin s = sx - sy; e.err = !in_range(s); e.carry = (ux < uy); end
            4'd2: begin s = sx - 1;  e.err = !in_range(s); e.carry = (ux == 0); end
            4'd3: begin s = sx + 1;  e.err = !in_range(s); e.carry = (ux == (longint'(1) << W) - 1); end
            4'd4: s = ~ux;
            4'd5: s = ux & uy;
            4'd6: s = ux | uy;
            4'd7: s = ux ^ uy;
            4'd8: s = (uy >= W) ? 0 : (ux << uy);
            4'd9: s = (uy >= W) ? 0 : (ux >> uy);
            4'd10: s = (uy >= W) ? ((sx < 0) ? -1 : 0) : (sx >>> uy);
`ifdef ALU_PIPE_MUL_EN
            4'd11: begin s = sx * sy; e.err = !in_range(s); end
`endif
            default: begin s = 0; e.err = 1'b1; end
        endcase
        e.res = s[W-1:0];
        return e;
    endfunction

    // Scoreboard producer: an accept happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) q.push_back(model(op, a, b));
    end

    // Scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_res", res, e.res);
                chk("sb_err", err, e.err);
                chk("sb_carry", carry, e.carry);
                chk("sb_zero", zero, (e.res == '0));
                chk("sb_neg", neg, e.res[W-1]);
            end
        end
    end

    // Outputs must hold while the sink stalls.
    logic        hold_prev = 1'b0;
    logic [11:0] prev_bundle = '0;
    always @(negedge clk) begin
        if (!rst && hold_prev) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_outputs", {res, err, carry, zero, neg}, prev_bundle);
        end
        hold_prev = !rst && out_valid && !out_ready;
        prev_bundle = {res, err, carry, zero, neg};
    end

    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output logic [W-1:0] r, output logic e,
                         output logic c, output logic n, output logic busy_rdy);
        int waitc;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = x; b = y;
        waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 50) begin @(negedge clk); waitc++; end
        @(posedge clk); #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 4'($urandom);
        lat = 1; busy_rdy = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_rdy = 1'b1;
            @(negedge clk);
            lat++;
        end
        r = res; e = err; c = carry; n = neg;
    endtask

    initial begin
        int           lat;
        logic [W-1:0] r;
        logic         e, c, n, br, saw;
        int           cyc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_res", res, 8'h00);
        chk("rst_zero", zero, 1'b1);
        chk("rst_neg", neg, 1'b0);
        chk("rst_err_carry", {err, carry}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);

        do_op(4'b0000, 8'd100, 8'd50, lat, r, e, c, n, br);
        chk("add_latency", lat, 1);
        chk("add_res", r, 8'h96);
        chk("add_err_carry", {e, c}, 2'b10);
        chk("add_neg", n, 1'b1);

        do_op(4'b0001, 8'h80, 8'd1, lat, r, e, c, n, br);
        chk("sub_min_res", r, 8'h7F);
        chk("sub_min_err_carry", {e, c}, 2'b10);
        do_op(4'b0001, 8'd3, 8'd5, lat, r, e, c, n, br);
        chk("sub_borrow_res", r, 8'hFE);
        chk("sub_borrow_err_carry", {e, c}, 2'b01);

        do_op(4'b1010, 8'h90, 8'd9, lat, r, e, c, n, br);
        chk("sar_big_res", r, 8'hFF);
        do_op(4'b1100, 8'h12, 8'h34, lat, r, e, c, n, br);
        chk("illegal_latency", lat, 1);
        chk("illegal_res_err", {r, e}, {8'h00, 1'b1});

`ifdef ALU_PIPE_MUL_EN
        do_op(MUL_OP, 8'hF4, 8'd10, lat, r, e, c, n, br);
        chk("mul_latency", lat, W + 1);
        chk("mul_res_err", {r, e}, {8'h88, 1'b0});
        chk("mul_busy_in_ready", br, 1'b0);
        do_op(MUL_OP, 8'd16, 8'd8, lat, r, e, c, n, br);
        chk("mul_ovf_res_err", {r, e}, {8'h80, 1'b1});
`else
        do_op(MUL_OP, 8'hF4, 8'd10, lat, r, e, c, n, br);
        chk("mul_off_latency", lat, 1);
        chk("mul_off_res_err", {r, e}, {8'h00, 1'b1});
`endif

        // backpressure: result must hold and no new operands accepted
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_op(4'b0000, 8'd7, 8'd9, lat, r, e, c, n, br);
        chk("stall_latency", lat, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_res", res, 8'd16);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;

        // back-to-back stream, one result per cycle
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; op = 4'b0000; a = W'($urandom); b = W'(i * 17);
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1'b1);
            if (i > 0) chk("stream_out_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_valid", out_valid, 1'b1);
        @(posedge clk); #1;

        // reset aborts an in-flight operation
`ifdef ALU_PIPE_MUL_EN
        in_valid = 1'b1; op = MUL_OP; a = 8'd5; b = 8'd7;
`else
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'b0000; a = 8'd5; b = 8'd7;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_zero", zero, 1'b1);
        chk("abort_res", res, 8'h00);
        chk("abort_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("abort_in_ready_after", in_ready, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) saw = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_output", saw, 1'b0);

        // random traffic with random backpressure
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: a = 8'h00;
                1: a = 8'h7F;
                2: a = 8'h80;
                3: a = 8'hFF;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b = 8'h01;
                1: b = 8'h80;
                2: b = W'($urandom_range(0, 12));
                3: b = 8'hFF;
                default: b = W'($urandom);
            endcase
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's 6-bit combinational ALU. It registers every result, adds shift operations and an optional iterative signed multiply, and reports zero/negative/carry/overflow flags with corrected signed-overflow rules. It sits between an operand source and a result sink, with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 8: operand/result width, two's complement; must be ≥ 4 and a power of two.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands/opcode valid.
- `in_ready`  out  1  block can accept; transfer when `in_valid & in_ready` at a rising edge.
- `a`  in  WIDTH  first operand.
- `b`  in  WIDTH  second operand; shift amount (unsigned) for shifts.
- `op`  in  4  opcode.
- `out_valid`  out  1  result/flags valid.
- `out_ready`  in  1  sink accepts; transfer when `out_valid & out_ready`.
- `res`  out  WIDTH  result.
- `err`  out  1  signed overflow, or illegal opcode.
- `carry`  out  1  unsigned carry-out (ADD/INC) or borrow (SUB/DEC); 0 otherwise.
- `zero`  out  1  `res == 0`.
- `neg`  out  1  `res[WIDTH-1]`.

## Operation
- Opcodes:
  - 0000 ADD a+b; err when a and b have the same sign and res differs.
  - 0001 SUB a−b; err when a and b differ in sign and res sign ≠ a sign; carry = (a < b unsigned).
  - 0010 DEC a−1; err when a = −2^(W−1); carry when a = 0.
  - 0011 INC a+1; err when a = 2^(W−1)−1; carry when a = all-ones.
  - 0100 NOT ~a.
  - 0101 AND, 0110 OR, 0111 XOR.
  - 1000 SHL, 1001 SHR (logical), 1010 SAR (arithmetic). For b ≥ WIDTH: SHL/SHR give 0 and SAR gives all sign bits. err = 0 for all shifts.
  - 1011 MUL: signed a×b, res = low WIDTH bits; err when the full product is outside [−2^(W−1), 2^(W−1)−1].
  - 1100–1111: illegal; res = 0, err = 1.
- For NOT, logic, shift and illegal ops, carry = 0 and err = 0 unless stated above. `zero` and `neg` are always derived from the registered res.
- FSM states:
  - IDLE: in_ready = 1. An accepted non-MUL op goes to DONE. An accepted MUL goes to BUSY.
  - BUSY: shift-add over operand magnitudes, one bit per cycle, WIDTH cycles. Then negate if signs differ, then go to DONE. in_ready = 0.
  - DONE: out_valid = 1 and outputs held stable. When out_ready: if `in_valid` is also high, accept the new op in the same cycle (in_ready = out_ready) and go to DONE or BUSY; otherwise go to IDLE.
- Reset (rst high at an edge): state IDLE, out_valid = 0, res = 0, err = carry = 0, zero = 1, neg = 0. in_ready = 0 while rst is high. Reset in BUSY or DONE discards the operation and produces no output.

## Timing
- Single-cycle ops: out_valid rises in the cycle after the accept edge (latency 1). Throughput is 1 op/cycle while out_ready is held high.
- MUL: out_valid rises WIDTH+1 cycles after the accept edge (9 for WIDTH = 8).
- Operands are captured at the accept edge. Later changes to a, b or op have no effect.
- Outputs are registered. While out_valid = 1 and out_ready = 0, res and all flags hold.
- in_ready is combinational from the state and out_ready only, never from in_valid.

## Configuration
- `ALU_PIPE_MUL_EN` defined: MUL (1011) is implemented as above, including the multiplier datapath and the BUSY state.
- Not defined: 1011 is treated as an illegal opcode (res = 0, err = 1, latency 1). No multiplier logic and no BUSY state are built.

## Test plan
- WIDTH = 8, ADD a = 100, b = 50 → res 0x96, err 1, carry 0, neg 1, zero 0; out_valid exactly 1 cycle after accept.
- SUB a = 0x80 (−128), b = 1 → res 0x7F, err 1, carry 0. SUB a = 3, b = 5 → res 0xFE, err 0, carry 1.
- MUL (macro on) a = −12, b = 10 → res 0x88, err 0, out_valid 9 cycles after accept. a = 16, b = 8 → res 0x80, err 1. in_ready 0 throughout BUSY.
- Hold out_ready low 3 cycles after a result → res and flags stable, in_ready 0. Then stream 4 ADDs with out_ready high → one result per cycle, in order.
- Assert rst on cycle 4 of a MUL → out_valid never rises for it, zero = 1 after reset, in_ready 1 the cycle after rst drops.
- Opcodes 1100 and (macro off) 1011 → res 0, err 1, latency 1. SAR a = 0x90, b = 9 → res 0xFF.
